// File: rtl/pn_engine_pkg.sv
// Shared types for the Petri-net firing engine: FSM states and arc-vector indexing.
package pn_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } pn_state_e;

  // Flat arc vectors are row-major: row = transition, column = place (or transition).
  function automatic int arc_idx(input int row, input int col, input int ncol);
    return row * ncol + col;
  endfunction

endpackage

// File: rtl/pn_trans_cap.sv
// Per-transition capacity: min token count over input places, gated by inhibitor arcs.
module pn_trans_cap
  import pn_engine_pkg::*;
#(
  parameter int                    NUM_PLACES = 4,
  parameter int                    TOK_W      = 6,
  parameter logic [NUM_PLACES-1:0] PRE_ROW    = '0,
  parameter logic [NUM_PLACES-1:0] INH_ROW    = '0
) (
  input  logic [NUM_PLACES-1:0][TOK_W-1:0] marking_i,
  output logic [TOK_W-1:0]                 cap_o,
  output logic                             raw_en_o
);

  logic [TOK_W-1:0] cap_v;
  logic             has_pre;
  logic             inhibited;

  always_comb begin
    cap_v     = '1;
    has_pre   = 1'b0;
    inhibited = 1'b0;
    for (int p = 0; p < NUM_PLACES; p++) begin
      if (PRE_ROW[p]) begin
        has_pre = 1'b1;
        if (marking_i[p] < cap_v) cap_v = marking_i[p];
      end
      if (INH_ROW[p] && (marking_i[p] != '0)) inhibited = 1'b1;
    end
    // A transition without input arcs is a source; treat it as never enabled.
    if (!has_pre) cap_v = '0;
  end

  assign cap_o    = cap_v;
  assign raw_en_o = (cap_v != '0) && !inhibited;

endmodule

// File: rtl/pn_engine.sv
// Petri-net firing engine: fires the lowest-index enabled transition each cycle until deadlock.
module pn_engine
  import pn_engine_pkg::*;
#(
  parameter int                              NUM_PLACES = 4,
  parameter int                              NUM_TRANS  = 3,
  parameter int                              TOK_W      = 6,
  parameter int                              CNT_W      = 30,
  parameter logic [NUM_PLACES*TOK_W-1:0]     INIT_MARK  = {6'd0, 6'd0, 6'd0, 6'd2},
  parameter logic [NUM_TRANS*NUM_PLACES-1:0] PRE        = 12'b0100_0010_0001,
  parameter logic [NUM_TRANS*NUM_PLACES-1:0] POST       = 12'b1000_0100_0010,
  parameter logic [NUM_TRANS*NUM_PLACES-1:0] INH        = '0,
  parameter logic [NUM_TRANS*NUM_TRANS-1:0]  SUPPRESS   = '0,
  localparam int                             IDX_W      = $clog2(NUM_TRANS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        mode_single_i,
  input  logic                        step_en_i,
  input  logic                        step_i,
  output logic [NUM_PLACES*TOK_W-1:0] marking_o,
  output logic [CNT_W-1:0]            fire_count_o,
  output logic [IDX_W-1:0]            fired_idx_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam logic [TOK_W:0] TOK_MAX = {1'b0, {TOK_W{1'b1}}};

  pn_state_e                       state_q;
  logic [NUM_PLACES-1:0][TOK_W-1:0] marking_q, marking_d;
  logic [CNT_W-1:0]                fire_count_q;
  logic [IDX_W-1:0]                fired_idx_q;
  logic                            done_q, overflow_q;

  logic [NUM_TRANS-1:0][TOK_W-1:0] cap;
  logic [NUM_TRANS-1:0]            raw_en, en;
  logic                            sel_vld, ovf;
  int                              sel;
  logic [TOK_W:0]                  tc, sum;

  for (genvar t = 0; t < NUM_TRANS; t++) begin : g_cap
    pn_trans_cap #(
      .NUM_PLACES(NUM_PLACES),
      .TOK_W     (TOK_W),
      .PRE_ROW   (PRE[t*NUM_PLACES +: NUM_PLACES]),
      .INH_ROW   (INH[t*NUM_PLACES +: NUM_PLACES])
    ) u_cap (
      .marking_i(marking_q),
      .cap_o    (cap[t]),
      .raw_en_o (raw_en[t])
    );
    // Conflict resolution looks at raw enables so suppression cannot chase itself.
    assign en[t] = raw_en[t] && !(|(SUPPRESS[t*NUM_TRANS +: NUM_TRANS] & raw_en));
  end

  always_comb begin
    sel_vld = 1'b0;
    sel     = 0;
    for (int t = NUM_TRANS - 1; t >= 0; t--) begin
      if (en[t]) begin
        sel_vld = 1'b1;
        sel     = t;
      end
    end
    tc        = mode_single_i ? (TOK_W+1)'(1) : {1'b0, cap[sel]};
    ovf       = 1'b0;
    marking_d = marking_q;
    for (int p = 0; p < NUM_PLACES; p++) begin
      sum = {1'b0, marking_q[p]};
      if (PRE[arc_idx(sel, p, NUM_PLACES)])  sum = sum - tc;
      if (POST[arc_idx(sel, p, NUM_PLACES)]) sum = sum + tc;
      if (sum > TOK_MAX) ovf = 1'b1;
      marking_d[p] = sum[TOK_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      marking_q    <= INIT_MARK;
      fire_count_q <= '0;
      fired_idx_q  <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      fired_idx_q <= '0;
      case (state_q)
        ST_RUN: begin
          if (step_en_i || step_i) begin
            if (!sel_vld) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (ovf) begin
              state_q    <= ST_FAULT;
              overflow_q <= 1'b1;
            end else begin
              marking_q    <= marking_d;
              fire_count_q <= fire_count_q + 1'b1;
              fired_idx_q  <= IDX_W'(sel + 1);
            end
          end
        end
        default: begin
          if (start_i) begin
            state_q      <= ST_RUN;
            marking_q    <= INIT_MARK;
            fire_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign marking_o    = marking_q;
  assign fire_count_o = fire_count_q;
  assign fired_idx_o  = fired_idx_q;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_pn_engine.sv
// Directed bench for pn_engine: default chain net plus overflow and inhibitor variants.
module tb_pn_engine;

  logic clk = 1'b0;
  logic rst, start, start_ovf, start_inh, mode_single, step_en, step;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default chain net P0->P1->P2->P3, two tokens in P0.
  logic [23:0] mark;
  logic [29:0] cnt;
  logic [1:0]  idx;
  logic        busy, done, ovfl;

  pn_engine dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_single_i(mode_single),
    .step_en_i(step_en), .step_i(step), .marking_o(mark), .fire_count_o(cnt),
    .fired_idx_o(idx), .busy_o(busy), .done_o(done), .overflow_o(ovfl)
  );

  // Two places, 2-bit counters, both full, one arc P0->P1.
  logic [3:0]  o_mark;
  logic [29:0] o_cnt;
  logic        o_idx;
  logic        o_busy, o_done, o_ovfl;

  pn_engine #(
    .NUM_PLACES(2), .NUM_TRANS(1), .TOK_W(2), .CNT_W(30),
    .INIT_MARK(4'b11_11), .PRE(2'b01), .POST(2'b10), .INH(2'b00), .SUPPRESS(1'b0)
  ) dut_ovf (
    .clk_i(clk), .rst_i(rst), .start_i(start_ovf), .mode_single_i(mode_single),
    .step_en_i(step_en), .step_i(step), .marking_o(o_mark), .fire_count_o(o_cnt),
    .fired_idx_o(o_idx), .busy_o(o_busy), .done_o(o_done), .overflow_o(o_ovfl)
  );

  // Default chain with T0 inhibited by P3, which starts with a token.
  logic [23:0] i_mark;
  logic [29:0] i_cnt;
  logic [1:0]  i_idx;
  logic        i_busy, i_done, i_ovfl;

  pn_engine #(
    .INIT_MARK({6'd1, 6'd0, 6'd0, 6'd2}), .INH(12'b0000_0000_1000)
  ) dut_inh (
    .clk_i(clk), .rst_i(rst), .start_i(start_inh), .mode_single_i(mode_single),
    .step_en_i(step_en), .step_i(step), .marking_o(i_mark), .fire_count_o(i_cnt),
    .fired_idx_o(i_idx), .busy_o(i_busy), .done_o(i_done), .overflow_o(i_ovfl)
  );

  localparam logic [23:0] M_INIT = 24'd2;
  localparam logic [23:0] M_END  = 24'd2 << 18;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (mark !== M_INIT || cnt !== 30'd0 || idx !== 2'd0 || busy !== 1'b0 ||
        done !== 1'b0 || ovfl !== 1'b0) begin
      bad++;
      $display("FAIL reset: mark=%h cnt=%0d idx=%0d busy=%b done=%b ovf=%b (want mark=%h, rest 0)",
               mark, cnt, idx, busy, done, ovfl, M_INIT);
    end
  endtask

  task automatic test_max_fire();
    logic [23:0] exp_m [3];
    exp_m[0] = 24'd2 << 6;
    exp_m[1] = 24'd2 << 12;
    exp_m[2] = M_END;
    mode_single = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || mark !== M_INIT || idx !== 2'd0) begin
      bad++;
      $display("FAIL maxfire_start: busy=%b mark=%h idx=%0d (want 1 %h 0)", busy, mark, idx, M_INIT);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (idx !== 2'(k + 1) || mark !== exp_m[k] || cnt !== 30'(k + 1) || done !== 1'b0) begin
        bad++;
        $display("FAIL maxfire_fire%0d: idx=%0d mark=%h cnt=%0d done=%b (want %0d %h %0d 0)",
                 k, idx, mark, cnt, done, k + 1, exp_m[k], k + 1);
      end
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || idx !== 2'd0 || cnt !== 30'd3 || mark !== M_END) begin
      bad++;
      $display("FAIL maxfire_done: done=%b busy=%b idx=%0d cnt=%0d mark=%h (want 1 0 0 3 %h)",
               done, busy, idx, cnt, mark, M_END);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_idx [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    mode_single = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || cnt !== 30'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_restart: done=%b cnt=%0d busy=%b (want 0 0 1)", done, cnt, busy);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (idx !== exp_idx[k]) begin
        bad++;
        $display("FAIL single_order%0d: idx=%0d want %0d", k, idx, exp_idx[k]);
      end
    end
    total++;
    if (mark !== M_END || cnt !== 30'd6) begin
      bad++;
      $display("FAIL single_final: mark=%h cnt=%0d (want %h 6)", mark, cnt, M_END);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b busy=%b (want 1 0)", done, busy);
    end
    mode_single = 1'b0;
  endtask

  task automatic test_overflow();
    start_ovf = 1'b1;
    tick();
    start_ovf = 1'b0;
    tick();
    total++;
    if (o_ovfl !== 1'b1 || o_mark !== 4'b1111 || o_busy !== 1'b0 || o_cnt !== 30'd0 ||
        o_idx !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL overflow: ovf=%b mark=%b busy=%b cnt=%0d idx=%0d done=%b (want 1 1111 0 0 0 0)",
               o_ovfl, o_mark, o_busy, o_cnt, o_idx, o_done);
    end
    tick();
    total++;
    if (o_ovfl !== 1'b1 || o_mark !== 4'b1111) begin
      bad++;
      $display("FAIL overflow_sticky: ovf=%b mark=%b (want 1 1111)", o_ovfl, o_mark);
    end
  endtask

  task automatic test_inhibit();
    start_inh = 1'b1;
    tick();
    start_inh = 1'b0;
    tick();
    total++;
    if (i_done !== 1'b1 || i_cnt !== 30'd0 || i_idx !== 2'd0 || i_busy !== 1'b0 ||
        i_mark !== {6'd1, 6'd0, 6'd0, 6'd2} || i_ovfl !== 1'b0) begin
      bad++;
      $display("FAIL inhibit: done=%b cnt=%0d idx=%0d busy=%b mark=%h (want 1 0 0 0 040002)",
               i_done, i_cnt, i_idx, i_busy, i_mark);
    end
  endtask

  task automatic test_step();
    step_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      total++;
      if (idx !== 2'(k + 1) || cnt !== 30'(k + 1)) begin
        bad++;
        $display("FAIL step_pulse%0d: idx=%0d cnt=%0d (want %0d %0d)", k, idx, cnt, k + 1, k + 1);
      end
      for (int j = 0; j < 3; j++) begin
        tick();
        total++;
        if (idx !== 2'd0 || cnt !== 30'(k + 1)) begin
          bad++;
          $display("FAIL step_idle%0d_%0d: idx=%0d cnt=%0d (want 0 %0d)", k, j, idx, cnt, k + 1);
        end
      end
    end
    // Dead marking, but no step: engine must stay in RUN.
    total++;
    if (mark !== M_END || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL step_hold: mark=%h busy=%b done=%b (want %h 1 0)", mark, busy, done, M_END);
    end
    step_en = 1'b1;
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL step_resume_done: done=%b busy=%b (want 1 0)", done, busy);
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (cnt !== 30'd1 || idx !== 2'd1) begin
      bad++;
      $display("FAIL midrun_pre: cnt=%0d idx=%0d (want 1 1)", cnt, idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (mark !== M_INIT || cnt !== 30'd0 || busy !== 1'b0 || idx !== 2'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: mark=%h cnt=%0d busy=%b idx=%0d done=%b (want %h 0 0 0 0)",
               mark, cnt, busy, idx, done, M_INIT);
    end
    tick();
    total++;
    if (busy !== 1'b0 || mark !== M_INIT) begin
      bad++;
      $display("FAIL midrun_idle: busy=%b mark=%h (want 0 %h)", busy, mark, M_INIT);
    end
    test_max_fire();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_ovf = 1'b0; start_inh = 1'b0;
    mode_single = 1'b0; step_en = 1'b1; step = 1'b0;
    test_reset();
    test_max_fire();
    test_single();
    test_overflow();
    test_inhibit();
    test_step();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
